responder_multi: RTL
====================

Name: responder_multi

Overview:
- Parametrised quiz responder (buzzer arbiter) for N_PLAYERS contestants.
- Successor to the fixed 4-player responder. Adds:
  - runtime-selectable active-player count
  - host-armed answer window with a countdown timer
  - false-start (foul) detection
  - deterministic lowest-index tie-break
  - explicit clear.
- Sits between debounced player buttons and the display/timer logic.

Parameters:
- N_PLAYERS, 8, number of player inputs (2..15).
- ID_W, 4, width of player-number fields. Must satisfy 2^ID_W > N_PLAYERS.
- TMR_W, 8, width of countdown counter.
- PRESCALE, 1000, clock cycles per countdown tick (>=1).
- ANSWER_TICKS, 30, countdown load value on arm (1..2^TMR_W-1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- showready  input  1  host arm request, level; armed on rising edge
- clear  input  1  host clear, level; returns block to IDLE
- players  input  N_PLAYERS  button levels; bit i = player i+1
- number_of_player  input  ID_W  count of enabled players. Players 1..number_of_player are active; values >N_PLAYERS clamp to N_PLAYERS; 0 = none enabled.
- result  output  ID_W  1-based winning player number, 0 = none
- foul  output  1  a false start occurred
- foul_id  output  ID_W  1-based number of the fouling player, 0 = none
- stoptimer  output  1  countdown frozen (winner locked)
- timeout  output  1  answer window expired with no press
- countdown  output  TMR_W  remaining ticks
- state  output  3  IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3, FOUL=4

Behaviour:
- Reset (rst=0, async): state=IDLE; result=0, foul=0, foul_id=0, stoptimer=0, timeout=0, countdown=0. Edge-detect registers and prescaler clear to 0.
- Input capture:
  - players and showready pass through one register stage (q1), then a second (q2).
  - press[i] = q1[i] & ~q2[i] & enabled[i].
  - arm = q1 & ~q2 of showready.
  - Latency: input high before edge k → press seen at edge k+1 → outputs update after edge k+1.
  - A player held high generates only one press.
- Tie-break: multiple simultaneous presses resolve to the lowest index (player 1 highest priority).
- IDLE:
  - Any press → FOUL: foul=1, foul_id=winner of tie-break.
  - Otherwise arm → ARMED: countdown=ANSWER_TICKS, prescaler=0.
  - Press and arm in the same cycle → FOUL; arm is ignored.
- ARMED:
  - Prescaler counts 0..PRESCALE-1; on wrap, countdown decrements.
  - Press → LOCKED: result=winner, stoptimer=1, countdown frozen at its current value.
  - If countdown reaches 0 with no press → TIMEOUT: timeout=1.
  - Press in the same cycle countdown would reach 0 → LOCKED. The press wins and countdown holds 1.
  - Further arm edges are ignored.
- LOCKED, TIMEOUT, FOUL:
  - All outputs hold.
  - Further presses and arm edges are ignored; a later player never overwrites result or foul_id.
- clear (sampled directly, synchronous, level):
  - In any state → IDLE next edge; result, foul, foul_id, stoptimer, timeout and countdown return to 0.
  - clear has priority over press and arm in the same cycle.
  - While clear is high the block stays in IDLE, and presses do not cause a foul.
- number_of_player:
  - Sampled every cycle.
  - Changing it mid-ARMED affects only subsequent presses.
  - Disabled players never produce result, foul or foul_id.
- Reset mid-operation returns to the reset values immediately, regardless of state.

Test Plan (N_PLAYERS=8, PRESCALE=4, ANSWER_TICKS=5):
1. Reset, number_of_player=4, pulse showready, raise player3 after 2 ticks → state=LOCKED, result=3, stoptimer=1, countdown=3; later player1 press leaves result=3.
2. Armed with number_of_player=8, raise players 6 and 2 on the same edge → result=2.
3. number_of_player=3, armed, raise player5 then let time expire → player5 ignored; after 5×4 cycles countdown=0, timeout=1, result=0, state=TIMEOUT.
4. In IDLE raise player4 → foul=1, foul_id=4, state=FOUL. Then a showready pulse → no change. clear → all outputs 0, state=IDLE.
5. Armed and locked with result=7, assert rst=0 between clock edges → outputs 0 immediately, before the next clk edge.
6. Player1 press on the exact cycle countdown would reach 0 → LOCKED, result=1, countdown=1, timeout=0.
7. number_of_player=12 → behaves as 8; player8 press yields result=8.

Source files
------------

// File: rtl/responder_multi.sv
// Quiz buzzer arbiter: arms an answer window with a countdown, locks the
// first (lowest-numbered) enabled press, and flags presses made before arming.

module responder_lane #(
    parameter int ID_W = 4,
    parameter int IDX  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn,
    input  logic [ID_W-1:0] n_eff,
    output logic            press
);
    logic q1, q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= btn;
            q2 <= q1;
        end
    end

    // The enable is applied to the edge itself, so a player enabled while
    // already holding the button never produces a late press.
    assign press = q1 & ~q2 & (ID_W'(IDX) < n_eff);
endmodule

module responder_multi #(
    parameter int N_PLAYERS    = 8,
    parameter int ID_W         = 4,
    parameter int TMR_W        = 8,
    parameter int PRESCALE     = 1000,
    parameter int ANSWER_TICKS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 showready,
    input  logic                 clear,
    input  logic [N_PLAYERS-1:0] players,
    input  logic [ID_W-1:0]      number_of_player,
    output logic [ID_W-1:0]      result,
    output logic                 foul,
    output logic [ID_W-1:0]      foul_id,
    output logic                 stoptimer,
    output logic                 timeout,
    output logic [TMR_W-1:0]     countdown,
    output logic [2:0]           state
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if ((1 << ID_W) <= N_PLAYERS) begin : g_bad_id_w
        $error("ID_W too narrow for N_PLAYERS");
    end
    if (N_PLAYERS < 2 || PRESCALE < 1 || ANSWER_TICKS < 1 || ANSWER_TICKS >= (1 << TMR_W)) begin : g_bad_par
        $error("responder_multi parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        LOCKED  = 3'd2,
        TIMEOUT = 3'd3,
        FOUL    = 3'd4
    } state_t;

    state_t            st_q, st_d;
    logic [ID_W-1:0]   result_q, result_d;
    logic              foul_q, foul_d;
    logic [ID_W-1:0]   foul_id_q, foul_id_d;
    logic              stop_q, stop_d;
    logic              tmo_q, tmo_d;
    logic [TMR_W-1:0]  cnt_q, cnt_d;
    logic [PS_W-1:0]   presc_q, presc_d;

    logic [ID_W-1:0]      n_eff;
    logic [N_PLAYERS-1:0] press;
    logic                 any_press;
    logic [ID_W-1:0]      win_id;
    logic                 sr_q1, sr_q2, arm;

    assign n_eff = (number_of_player > ID_W'(N_PLAYERS)) ? ID_W'(N_PLAYERS) : number_of_player;

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
        responder_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .btn   (players[i]),
            .n_eff (n_eff),
            .press (press[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q1 <= 1'b0;
            sr_q2 <= 1'b0;
        end else begin
            sr_q1 <= showready;
            sr_q2 <= sr_q1;
        end
    end
    assign arm = sr_q1 & ~sr_q2;

    // Scan high to low so the lowest index overwrites: player 1 wins ties.
    always_comb begin
        win_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (press[i]) win_id = ID_W'(i + 1);
        end
    end
    assign any_press = |press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= IDLE;
            result_q  <= '0;
            foul_q    <= 1'b0;
            foul_id_q <= '0;
            stop_q    <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            presc_q   <= '0;
        end else begin
            st_q      <= st_d;
            result_q  <= result_d;
            foul_q    <= foul_d;
            foul_id_q <= foul_id_d;
            stop_q    <= stop_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        result_d  = result_q;
        foul_d    = foul_q;
        foul_id_d = foul_id_q;
        stop_d    = stop_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        if (clear) begin
            st_d      = IDLE;
            result_d  = '0;
            foul_d    = 1'b0;
            foul_id_d = '0;
            stop_d    = 1'b0;
            tmo_d     = 1'b0;
            cnt_d     = '0;
            presc_d   = '0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (any_press) begin
                        st_d      = FOUL;
                        foul_d    = 1'b1;
                        foul_id_d = win_id;
                    end else if (arm) begin
                        st_d    = ARMED;
                        cnt_d   = TMR_W'(ANSWER_TICKS);
                        presc_d = '0;
                    end
                end
                ARMED: begin
                    // A press beats the final tick: the count stays frozen at 1.
                    if (any_press) begin
                        st_d     = LOCKED;
                        result_d = win_id;
                        stop_d   = 1'b1;
                    end else if (presc_q == PS_W'(PRESCALE - 1)) begin
                        presc_d = '0;
                        cnt_d   = cnt_q - TMR_W'(1);
                        if (cnt_q == TMR_W'(1)) begin
                            st_d  = TIMEOUT;
                            tmo_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                LOCKED, TIMEOUT, FOUL: ;
                default: st_d = IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign foul      = foul_q;
    assign foul_id   = foul_id_q;
    assign stoptimer = stop_q;
    assign timeout   = tmo_q;
    assign countdown = cnt_q;
    assign state     = st_q;
endmodule
